or_array_sweep_ctrl: RTL and testbench



---
 rtl/or_sweep_pkg.sv | 18 +
 rtl/or_sweep_opgen.sv | 31 +++
 rtl/or_array_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_or_array_sweep_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/or_sweep_pkg.sv
// Shared types and sizing helpers for the OR2 gate-array sweep controller.
package or_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int unsigned SETTLE_W = 4;

  // vec_count needs one extra bit so that 2^(2W) fits without wrapping.
  function automatic int unsigned vec_count_w(input int unsigned msb);
    return 2 * (msb + 1) + 1;
  endfunction

endpackage

// File: rtl/or_sweep_opgen.sv
// Operand pair counter: B is the inner digit, A the outer; both wrap silently.
module or_sweep_opgen #(
  parameter int unsigned MSB = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  output logic [MSB:0] a,
  output logic [MSB:0] b,
  output logic         last
);

  localparam int unsigned W = MSB + 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
    end else if (clear) begin
      a <= '0;
      b <= '0;
    end else if (advance) begin
      b <= b + W'(1);
      if (&b) a <= a + W'(1);
    end
  end

  assign last = (&a) & (&b);

endmodule

// File: rtl/or_array_sweep_ctrl.sv
// Clocked exhaustive-sweep checker for the per-bit OR2 gate array:
// drives every (A,B) pair, waits SETTLE cycles, compares Z against A|B.
module or_array_sweep_ctrl
  import or_sweep_pkg::*;
#(
  parameter int unsigned MSB          = 7,
  parameter int unsigned SETTLE       = 1,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic [MSB:0]                a_out,
  output logic [MSB:0]                b_out,
  input  logic [MSB:0]                z_in,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [MSB:0]                fail_a,
  output logic [MSB:0]                fail_b,
  output logic [MSB:0]                fail_z,
  output logic [vec_count_w(MSB)-1:0] vec_count
);

  localparam int unsigned VCW = vec_count_w(MSB);
  localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE - 1);

  state_t              state_q, state_nxt;
  logic [SETTLE_W-1:0] settle_q, settle_nxt;
  logic                fail_q, fail_nxt;
  logic                sweep_start;
  logic                op_advance;
  logic                cnt_inc;
  logic                capture;
  logic                last_c;
  logic                mismatch_c;

  or_sweep_opgen #(
    .MSB (MSB)
  ) u_opgen (
    .clk     (clk),
    .rst     (rst),
    .clear   (sweep_start),
    .advance (op_advance),
    .a       (a_out),
    .b       (b_out),
    .last    (last_c)
  );

  // Case-inequality so an undriven or unknown Z bit counts as a failure.
  assign mismatch_c = (z_in !== (a_out | b_out));

  always_comb begin
    state_nxt   = state_q;
    settle_nxt  = settle_q;
    fail_nxt    = fail_q;
    sweep_start = 1'b0;
    op_advance  = 1'b0;
    cnt_inc     = 1'b0;
    capture     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (start) begin
          sweep_start = 1'b1;
          fail_nxt    = 1'b0;
          settle_nxt  = SETTLE_RELOAD;
          state_nxt   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (settle_q == '0) begin
          state_nxt = S_CHECK;
        end else begin
          settle_nxt = settle_q - SETTLE_W'(1);
        end
      end
      S_CHECK: begin
        cnt_inc = 1'b1;
        if (mismatch_c && !fail_q) begin
          capture  = 1'b1;
          fail_nxt = 1'b1;
        end
        // The check in this cycle still counts even when aborted.
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (fail_nxt && STOP_ON_FAIL) begin
          state_nxt = S_DONE;
        end else if (last_c) begin
          state_nxt = S_DONE;
        end else begin
          op_advance = 1'b1;
          settle_nxt = SETTLE_RELOAD;
          state_nxt  = S_SETTLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      fail_q    <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_z    <= '0;
      vec_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      settle_q <= settle_nxt;
      fail_q   <= fail_nxt;
      if (sweep_start) begin
        fail_a <= '0;
        fail_b <= '0;
        fail_z <= '0;
      end else if (capture) begin
        fail_a <= a_out;
        fail_b <= b_out;
        fail_z <= z_in;
      end
      if (sweep_start) vec_count <= '0;
      else if (cnt_inc) vec_count <= vec_count + VCW'(1);
      // Status flags registered from the next state so they line up with it.
      busy <= (state_nxt == S_SETTLE) || (state_nxt == S_CHECK);
      done <= (state_nxt == S_DONE);
      pass <= (state_nxt == S_DONE) && !fail_nxt;
    end
  end

endmodule

// File: tb/tb_or_array_sweep_ctrl.sv
// Directed bench for or_array_sweep_ctrl: table of fault patterns on a 2-bit
// array plus hand-written reset, abort and slow-array sequences.
module tb_or_array_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance 0: MSB=1, SETTLE=1, stop on first failure; stuck-at masks from the bench.
  logic       start0 = 1'b0, abort0 = 1'b0;
  logic [1:0] a0, b0, z0, fa0, fb0, fz0;
  logic [1:0] f0 = 2'b00, f1 = 2'b00;
  logic       busy0, done0, pass0;
  logic [4:0] vc0;
  assign z0 = ((a0 | b0) & ~f0) | f1;

  or_array_sweep_ctrl #(.MSB(1), .SETTLE(1), .STOP_ON_FAIL(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .a_out(a0), .b_out(b0), .z_in(z0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_a(fa0), .fail_b(fb0), .fail_z(fz0), .vec_count(vc0));

  // Instance 1: MSB=1, run to the end; bit 0 of Z stuck at 0.
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [1:0] a1, b1, z1, fa1, fb1, fz1;
  logic       busy1, done1, pass1;
  logic [4:0] vc1;
  assign z1 = (a1 | b1) & 2'b10;

  or_array_sweep_ctrl #(.MSB(1), .SETTLE(1), .STOP_ON_FAIL(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .a_out(a1), .b_out(b1), .z_in(z1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_a(fa1), .fail_b(fb1), .fail_z(fz1), .vec_count(vc1));

  // Instance 2: MSB=2, SETTLE=3, array modelled with two cycles of latency.
  logic       start2 = 1'b0, abort2 = 1'b0;
  logic [2:0] a2, b2, z2, fa2, fb2, fz2, zd1, zd2;
  logic       busy2, done2, pass2;
  logic [6:0] vc2;
  always_ff @(posedge clk) begin
    zd1 <= a2 | b2;
    zd2 <= zd1;
  end
  assign z2 = zd2;

  or_array_sweep_ctrl #(.MSB(2), .SETTLE(3), .STOP_ON_FAIL(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .a_out(a2), .b_out(b2), .z_in(z2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_a(fa2), .fail_b(fb2), .fail_z(fz2), .vec_count(vc2));

  typedef struct {
    logic [1:0] f0;
    logic [1:0] f1;
    int         cycles;
    logic       pass;
    logic [1:0] fa, fb, fz, ea, eb;
    logic [4:0] vc;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start a sweep on instance 0; optionally re-pulse start while busy at cycle 'extra'.
  task automatic run0(input int extra, output int cyc);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; cyc = 0;
    while (!done0 && cyc < 2000) begin
      start0 = (extra > 0 && cyc == extra);
      @(negedge clk); cyc++;
    end
    start0 = 1'b0;
  endtask

  task automatic wait_pair0(input logic [1:0] ea, input logic [1:0] eb);
    int k = 0;
    while (!(a0 == ea && b0 == eb && busy0) && k < 200) begin
      @(negedge clk); k++;
    end
    check("wait_pair_timeout", 32'(k < 200), 32'd1);
  endtask

  initial begin
    int cyc;

    //            f0     f1     cyc pass fa     fb     fz     a      b      vc
    vt[0] = '{2'b00, 2'b00, 32, 1'b1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 5'd16};
    vt[1] = '{2'b01, 2'b00,  4, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 5'd2};
    vt[2] = '{2'b10, 2'b00,  6, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2, 5'd3};
    vt[3] = '{2'b11, 2'b00,  4, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 5'd2};
    vt[4] = '{2'b00, 2'b10,  2, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 5'd1};
    vt[5] = '{2'b00, 2'b00, 32, 1'b1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 5'd16};

    // Reset state
    @(negedge clk);
    check("rst_a", 32'(a0), 32'd0);
    check("rst_b", 32'(b0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_pass", 32'(pass0), 32'd0);
    check("rst_vc", 32'(vc0), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Table of fault patterns, each sweep restarted from the previous DONE
    for (int i = 0; i < 6; i++) begin
      f0 = vt[i].f0;
      f1 = vt[i].f1;
      run0(0, cyc);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vt[i].cycles));
      check($sformatf("v%0d_done", i), 32'(done0), 32'd1);
      check($sformatf("v%0d_pass", i), 32'(pass0), 32'(vt[i].pass));
      check($sformatf("v%0d_fail_a", i), 32'(fa0), 32'(vt[i].fa));
      check($sformatf("v%0d_fail_b", i), 32'(fb0), 32'(vt[i].fb));
      check($sformatf("v%0d_fail_z", i), 32'(fz0), 32'(vt[i].fz));
      check($sformatf("v%0d_a", i), 32'(a0), 32'(vt[i].ea));
      check($sformatf("v%0d_b", i), 32'(b0), 32'(vt[i].eb));
      check($sformatf("v%0d_vc", i), 32'(vc0), 32'(vt[i].vc));
    end
    f0 = 2'b00;
    f1 = 2'b00;

    // Asynchronous reset mid-SETTLE at pair (1,2)
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    wait_pair0(2'd1, 2'd2);
    check("pre_rst_vc", 32'(vc0), 32'd6);
    #2 rst = 1'b1;
    #1;
    check("async_rst_a", 32'(a0), 32'd0);
    check("async_rst_b", 32'(b0), 32'd0);
    check("async_rst_busy", 32'(busy0), 32'd0);
    check("async_rst_vc", 32'(vc0), 32'd0);
    @(negedge clk); rst = 1'b0;
    run0(0, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd32);
    check("post_rst_pass", 32'(pass0), 32'd1);
    check("post_rst_vc", 32'(vc0), 32'd16);

    // Abort during CHECK of vector 5, pair (1,1)
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    wait_pair0(2'd1, 2'd1);
    check("pre_abort_vc", 32'(vc0), 32'd5);
    @(negedge clk); abort0 = 1'b1;
    @(negedge clk); abort0 = 1'b0;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_done", 32'(done0), 32'd0);
    check("abort_pass", 32'(pass0), 32'd0);
    check("abort_vc", 32'(vc0), 32'd6);
    repeat (3) @(negedge clk);
    check("abort_idle_vc", 32'(vc0), 32'd6);

    // Abort and start together in IDLE: stays idle
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk); start0 = 1'b0; abort0 = 1'b0;
    check("abort_start_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    check("abort_start_vc", 32'(vc0), 32'd6);

    // start while busy must not disturb the sweep
    run0(9, cyc);
    check("busy_start_cycles", 32'(cyc), 32'd32);
    check("busy_start_pass", 32'(pass0), 32'd1);
    check("busy_start_vc", 32'(vc0), 32'd16);

    // Run-to-end instance keeps the first mismatch
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; cyc = 0;
    while (!done1 && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    check("nostop_cycles", 32'(cyc), 32'd32);
    check("nostop_pass", 32'(pass1), 32'd0);
    check("nostop_vc", 32'(vc1), 32'd16);
    check("nostop_fail_a", 32'(fa1), 32'd0);
    check("nostop_fail_b", 32'(fb1), 32'd1);
    check("nostop_fail_z", 32'(fz1), 32'd0);

    // Wider array with latency, SETTLE=3: 64 pairs x 4 cycles
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; cyc = 0;
    while (!done2 && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    check("slow_cycles", 32'(cyc), 32'd256);
    check("slow_pass", 32'(pass2), 32'd1);
    check("slow_vc", 32'(vc2), 32'd64);
    check("slow_a", 32'(a2), 32'd7);
    check("slow_b", 32'(b2), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
